// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples sclk/cs/mosi in the clk domain, deserialises
// MSB-first words and queues them in a show-ahead FIFO with valid/ready output.
module spi_slave_rx #(
    parameter int WIDTH       = 12,
    parameter int DEPTH       = 4,
    parameter int LEAD_IN     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       cs,
    input  logic                       mosi,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (LEAD_IN > 0) ? $clog2(LEAD_IN + 1) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, LEAD, SHIFT, HOLD} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, flush_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s, fall, sync_ready;

    state_t            state_q, state_d;
    logic [LW-1:0]     lead_cnt_q, lead_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              push_req_q, push_req_d;
    logic              frame_err_q, frame_err_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              full, empty, do_push, do_pop;

    // flush_q fills with ones once the sync chains hold real pin samples, so the
    // reset value of the cs chain cannot release WAIT_IDLE in the middle of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q[0] <= sclk;
            cs_sync_q[0]   <= cs;
            mosi_sync_q[0] <= mosi;
            flush_q[0]     <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
                flush_q[i]     <= flush_q[i-1];
            end
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sync_ready = flush_q[SYNC_STAGES-1];
    assign fall       = sclk_prev_q & ~sclk_s;

    always_comb begin
        state_d     = state_q;
        lead_cnt_d  = lead_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        push_req_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_IDLE: if (sync_ready && cs_s) state_d = IDLE;
            IDLE: begin
                if (!cs_s) begin
                    lead_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = (LEAD_IN == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                // cs release wins over a coincident fall
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (fall) begin
                    lead_cnt_d = lead_cnt_q + LW'(1);
                    if (lead_cnt_q + LW'(1) == LW'(LEAD_IN)) state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (fall) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        push_req_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD:    if (cs_s) state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            lead_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            push_req_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lead_cnt_q  <= lead_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            push_req_q  <= push_req_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = dout_ready && !empty;
    // a full FIFO still accepts the word when the head leaves in the same cycle
    assign do_push = push_req_q && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req_q && full && !do_pop) overflow_q <= 1'b1;
            else if (ovf_clr)                  overflow_q <= 1'b0;
        end
    end

    assign dout       = empty ? '0 : mem_q[rd_ptr_q];
    assign dout_valid = !empty;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed and randomized bench for spi_slave_rx; expected words come from a
// queue model fed with the bits the bench itself shifts out.
module tb_spi_slave_rx;
    localparam int WIDTH   = 12;
    localparam int DEPTH   = 4;
    localparam int LEAD_IN = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             sclk = 1'b0;
    logic             cs = 1'b1;
    logic             mosi = 1'b0;
    logic             dout_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [2:0]       fifo_count;
    logic             frame_err;
    logic             overflow;

    int               n_checks = 0;
    int               n_errors = 0;
    int               h = 11;
    int               ferr_seen = 0;
    int               ferr_exp = 0;
    logic             ovf_exp = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    spi_slave_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEAD_IN(LEAD_IN), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && frame_err === 1'b1) ferr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_cycle(input logic b);
        sclk = 1'b1;
        mosi = b;
        repeat (h) @(negedge clk);
        sclk = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    // mode 0: plain frame; 1: check push latency on an empty FIFO;
    // 2: hold dout_ready for exactly the cycle in which the word is written
    task automatic send_frame(input logic [WIDTH-1:0] w, input int ndata, input int mode);
        logic             bits[$];
        logic [WIDTH-1:0] mw;
        logic             b;
        cs = 1'b0;
        repeat (h) @(negedge clk);
        for (int i = 0; i < LEAD_IN; i++) sclk_cycle(1'($urandom_range(0, 1)));
        for (int d = 0; d < ndata; d++) begin
            b = (d < WIDTH) ? w[WIDTH-1-d] : 1'($urandom_range(0, 1));
            bits.push_back(b);
            sclk = 1'b1;
            mosi = b;
            repeat (h) @(negedge clk);
            sclk = 1'b0;
            if (d == WIDTH - 1 && mode == 1) begin
                repeat (3) @(negedge clk);
                check("valid_early", 32'(dout_valid), 0);
                @(negedge clk);
                check("valid_latency", 32'(dout_valid), 1);
                check("dout_latency", 32'(dout), 32'(w));
                repeat (h - 4) @(negedge clk);
            end else if (d == WIDTH - 1 && mode == 2) begin
                repeat (3) @(negedge clk);
                check("full_before_pop", 32'(fifo_count), DEPTH);
                dout_ready = 1'b1;
                @(negedge clk);
                dout_ready = 1'b0;
                repeat (h - 4) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
        end
        cs = 1'b1;
        repeat (h + 4) @(negedge clk);
        if (ndata >= WIDTH) begin
            mw = '0;
            for (int k = 0; k < WIDTH; k++) mw = {mw[WIDTH-2:0], bits[k]};
            if (mode == 2 && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(mw);
            else ovf_exp = 1'b1;
        end else begin
            ferr_exp++;
        end
        check("frame_err_count", ferr_seen, ferr_exp);
        check("fifo_count", 32'(fifo_count), exp_q.size());
        check("overflow", 32'(overflow), 32'(ovf_exp));
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check("drain_valid", 32'(dout_valid), 1);
            check("drain_dout", 32'(dout), 32'(exp_q[0]));
            dout_ready = 1'b1;
            @(negedge clk);
            dout_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check("drained_valid", 32'(dout_valid), 0);
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        dout_ready = 1'b0;
        check("pop_empty_count", 32'(fifo_count), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single word with latency
        send_frame(12'hA5C, WIDTH, 1);
        drain();

        // fill, overflow, drain in order
        send_frame(12'h001, WIDTH, 0);
        send_frame(12'h800, WIDTH, 0);
        send_frame(12'hFFF, WIDTH, 0);
        send_frame(12'h3C3, WIDTH, 0);
        send_frame(12'h555, WIDTH, 0);
        drain();
        check("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // aborted frame then a good one
        send_frame(12'hABC, 7, 0);
        send_frame(12'h123, WIDTH, 0);

        // fill to overflow so reset has something to clear
        for (int i = 0; i < 4; i++) send_frame(12'($urandom), WIDTH, 0);

        // reset during bit 5 with cs held low
        cs = 1'b0;
        repeat (h) @(negedge clk);
        for (int i = 0; i < LEAD_IN + 4; i++) sclk_cycle(1'($urandom_range(0, 1)));
        sclk = 1'b1;
        mosi = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_dout", 32'(dout), 0);
        check("midrst_valid", 32'(dout_valid), 0);
        check("midrst_count", 32'(fifo_count), 0);
        check("midrst_frame_err", 32'(frame_err), 0);
        check("midrst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        exp_q.delete();
        ovf_exp = 1'b0;
        repeat (h) @(negedge clk);
        sclk = 1'b0;
        repeat (h) @(negedge clk);
        for (int i = 0; i < WIDTH - 5; i++) sclk_cycle(1'($urandom_range(0, 1)));
        cs = 1'b1;
        repeat (h + 4) @(negedge clk);
        check("postrst_count", 32'(fifo_count), 0);
        check("postrst_frame_err", ferr_seen, ferr_exp);
        send_frame(12'h7E1, WIDTH, 0);
        drain();

        // full FIFO with a pop coinciding with the push
        for (int i = 0; i < DEPTH; i++) send_frame(12'($urandom), WIDTH, 0);
        send_frame(12'h6D9, WIDTH, 2);
        drain();

        // more falls than bits while cs stays low
        send_frame(12'hB2D, WIDTH + 2, 0);
        drain();

        // randomized frames, lengths, sclk rates and drain points
        for (int n = 0; n < 12; n++) begin
            h = $urandom_range(4, 12);
            send_frame(12'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(1, WIDTH - 1) : WIDTH, 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("final_ovf_clear", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
